// File: rtl/edge_rate_counter.sv
// Gated edge-rate meter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clocks and tracks min/max edge-to-edge period.
module edge_rate_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             overflow,
  output logic             no_period
);
  localparam int              GW    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]   GLAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   hist, rise;
  logic [GW-1:0]          gate_cnt;
  logic                   gate_last;
  logic [CNT_W-1:0]       edge_cnt, ie_cnt, min_r, max_r;
  logic                   first_seen, ovf_r;
  logic [CNT_W-1:0]       ie_inc, edge_inc;
  logic                   ie_sat, edge_sat;
  logic [CNT_W-1:0]       edge_nxt, ie_nxt, min_nxt, max_nxt;
  logic                   first_nxt, ovf_nxt;

  // Synchronizer and history flop run in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      hist      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sig_in};
      hist      <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign rise = sync_pipe[SYNC_STAGES-1] & ~hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_GATE;
      S_GATE:  if (gate_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_GATE);
    done = (state == S_DONE);
  end

  assign gate_last = (gate_cnt == GLAST);
  assign ie_inc    = (ie_cnt == CMAX) ? CMAX : ie_cnt + 1'b1;
  assign ie_sat    = (ie_inc == CMAX);
  assign edge_inc  = (edge_cnt == CMAX) ? CMAX : edge_cnt + 1'b1;
  assign edge_sat  = (edge_inc == CMAX);

  // Interval on a rise is the saturated (counter + 1), so simultaneous saturation is reported
  always_comb begin
    edge_nxt  = edge_cnt;
    ie_nxt    = ie_inc;
    first_nxt = first_seen;
    min_nxt   = min_r;
    max_nxt   = max_r;
    ovf_nxt   = ovf_r | ie_sat;
    if (rise) begin
      edge_nxt  = edge_inc;
      ovf_nxt   = ovf_r | ie_sat | edge_sat;
      ie_nxt    = '0;
      first_nxt = 1'b1;
      if (first_seen) begin
        if (ie_inc < min_r) min_nxt = ie_inc;
        if (ie_inc > max_r) max_nxt = ie_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ie_cnt     <= '0;
      first_seen <= 1'b0;
      min_r      <= CMAX;
      max_r      <= '0;
      ovf_r      <= 1'b0;
    end else if (state == S_IDLE && start) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ie_cnt     <= '0;
      first_seen <= 1'b0;
      min_r      <= CMAX;
      max_r      <= '0;
      ovf_r      <= 1'b0;
    end else if (state == S_GATE) begin
      gate_cnt   <= gate_cnt + 1'b1;
      edge_cnt   <= edge_nxt;
      ie_cnt     <= ie_nxt;
      first_seen <= first_nxt;
      min_r      <= min_nxt;
      max_r      <= max_nxt;
      ovf_r      <= ovf_nxt;
    end
  end

  // Results load on the last GATE edge so they are visible during the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      period_min <= '0;
      period_max <= '0;
      overflow   <= 1'b0;
      no_period  <= 1'b0;
    end else if (state == S_GATE && gate_last) begin
      edge_count <= edge_nxt;
      overflow   <= ovf_nxt;
      if (edge_nxt < CNT_W'(2)) begin
        no_period  <= 1'b1;
        period_min <= '0;
        period_max <= '0;
      end else begin
        no_period  <= 1'b0;
        period_min <= min_nxt;
        period_max <= max_nxt;
      end
    end
  end

endmodule

// File: tb/tb_edge_rate_counter.sv
// Directed bench for edge_rate_counter with an 8-bit counter build so saturation is reachable.
module tb_edge_rate_counter;
  localparam int G = 1000;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sig_in = 1'b0;
  logic         busy, done, overflow, no_period;
  logic [W-1:0] edge_count, period_min, period_max;

  int vec = 0;
  int err = 0;

  edge_rate_counter #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .busy(busy), .done(done), .edge_count(edge_count),
    .period_min(period_min), .period_max(period_max),
    .overflow(overflow), .no_period(no_period)
  );

  always #5 clk = ~clk;

  // Two-segment periodic pattern driven on negedges
  task automatic gen(input int ha, input int la, input int hb, input int lb, input int ncyc);
    int n;
    n = 0;
    @(negedge clk);
    while (n < ncyc) begin
      sig_in = 1'b1; repeat (ha) @(negedge clk);
      sig_in = 1'b0; repeat (la) @(negedge clk);
      sig_in = 1'b1; repeat (hb) @(negedge clk);
      sig_in = 1'b0; repeat (lb) @(negedge clk);
      n += ha + la + hb + lb;
    end
  endtask

  // lat: cycles from the start edge to done; bc: busy cycles; dn: done-high cycles
  task automatic run_window(input int pulse_at, output int lat, output int bc, output int dn);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 1; bc = int'(busy); dn = 0;
    while (!done && lat < 1100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
      start = (lat == pulse_at);
    end
    start = 1'b0;
    if (done) dn = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %b exp 0", busy); end
    vec++; if (done !== 1'b0) begin err++; $display("FAIL rst_done got %b exp 0", done); end
    vec++; if (edge_count !== 8'd0) begin err++; $display("FAIL rst_edge_count got %0d exp 0", edge_count); end
    vec++; if (period_min !== 8'd0) begin err++; $display("FAIL rst_period_min got %0d exp 0", period_min); end
    vec++; if (period_max !== 8'd0) begin err++; $display("FAIL rst_period_max got %0d exp 0", period_max); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    vec++; if (no_period !== 1'b0) begin err++; $display("FAIL rst_no_period got %b exp 0", no_period); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_periodic(input string tag);
    int lat, bc, dn;
    fork
      gen(2, 2, 2, 2, 1100);
      run_window(0, lat, bc, dn);
    join
    vec++; if (lat !== 1001) begin err++; $display("FAIL %s_latency got %0d exp 1001", tag, lat); end
    vec++; if (bc !== 1000) begin err++; $display("FAIL %s_busy_cycles got %0d exp 1000", tag, bc); end
    vec++; if (dn !== 1) begin err++; $display("FAIL %s_done_pulse got %0d exp 1", tag, dn); end
    vec++; if (edge_count < 8'd249 || edge_count > 8'd251) begin err++; $display("FAIL %s_edge_count got %0d exp 249..251", tag, edge_count); end
    vec++; if (period_min !== 8'd4) begin err++; $display("FAIL %s_period_min got %0d exp 4", tag, period_min); end
    vec++; if (period_max !== 8'd4) begin err++; $display("FAIL %s_period_max got %0d exp 4", tag, period_max); end
    vec++; if (no_period !== 1'b0) begin err++; $display("FAIL %s_no_period got %b exp 0", tag, no_period); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL %s_overflow got %b exp 0", tag, overflow); end
  endtask

  task automatic test_mixed;
    int lat, bc, dn;
    fork
      gen(2, 1, 2, 3, 1100);
      run_window(0, lat, bc, dn);
    join
    vec++; if (period_min !== 8'd3) begin err++; $display("FAIL mixed_period_min got %0d exp 3", period_min); end
    vec++; if (period_max !== 8'd5) begin err++; $display("FAIL mixed_period_max got %0d exp 5", period_max); end
    vec++; if (edge_count < 8'd249 || edge_count > 8'd251) begin err++; $display("FAIL mixed_edge_count got %0d exp 249..251", edge_count); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL mixed_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_constant;
    int lat, bc, dn;
    for (int lvl = 0; lvl < 2; lvl++) begin
      @(negedge clk); sig_in = lvl[0];
      repeat (5) @(negedge clk);
      run_window(0, lat, bc, dn);
      vec++; if (edge_count !== 8'd0) begin err++; $display("FAIL const%0d_edge_count got %0d exp 0", lvl, edge_count); end
      vec++; if (no_period !== 1'b1) begin err++; $display("FAIL const%0d_no_period got %b exp 1", lvl, no_period); end
      vec++; if (period_min !== 8'd0) begin err++; $display("FAIL const%0d_period_min got %0d exp 0", lvl, period_min); end
      vec++; if (period_max !== 8'd0) begin err++; $display("FAIL const%0d_period_max got %0d exp 0", lvl, period_max); end
    end
    @(negedge clk); sig_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_edge;
    int lat, bc, dn;
    fork
      begin
        @(negedge clk);
        repeat (100) @(negedge clk);
        sig_in = 1'b1;
      end
      run_window(0, lat, bc, dn);
    join
    @(negedge clk); sig_in = 1'b0;
    vec++; if (edge_count !== 8'd1) begin err++; $display("FAIL single_edge_count got %0d exp 1", edge_count); end
    vec++; if (no_period !== 1'b1) begin err++; $display("FAIL single_no_period got %b exp 1", no_period); end
    vec++; if (period_max !== 8'd0) begin err++; $display("FAIL single_period_max got %0d exp 0", period_max); end
  endtask

  task automatic test_sat_edges;
    int lat, bc, dn;
    fork
      gen(1, 1, 1, 1, 1100);
      run_window(0, lat, bc, dn);
    join
    vec++; if (edge_count !== 8'd255) begin err++; $display("FAIL sat_edge_count got %0d exp 255", edge_count); end
    vec++; if (overflow !== 1'b1) begin err++; $display("FAIL sat_edge_overflow got %b exp 1", overflow); end
    vec++; if (period_min !== 8'd2) begin err++; $display("FAIL sat_edge_period_min got %0d exp 2", period_min); end
    vec++; if (period_max !== 8'd2) begin err++; $display("FAIL sat_edge_period_max got %0d exp 2", period_max); end
  endtask

  task automatic test_sat_period;
    int lat, bc, dn;
    fork
      begin
        @(negedge clk);
        repeat (10) @(negedge clk);
        sig_in = 1'b1;
        repeat (400) @(negedge clk);
        sig_in = 1'b0;
        repeat (490) @(negedge clk);
        sig_in = 1'b1;
      end
      run_window(0, lat, bc, dn);
    join
    @(negedge clk); sig_in = 1'b0;
    vec++; if (edge_count !== 8'd2) begin err++; $display("FAIL satp_edge_count got %0d exp 2", edge_count); end
    vec++; if (no_period !== 1'b0) begin err++; $display("FAIL satp_no_period got %b exp 0", no_period); end
    vec++; if (period_min !== 8'd255) begin err++; $display("FAIL satp_period_min got %0d exp 255", period_min); end
    vec++; if (period_max !== 8'd255) begin err++; $display("FAIL satp_period_max got %0d exp 255", period_max); end
    vec++; if (overflow !== 1'b1) begin err++; $display("FAIL satp_overflow got %b exp 1", overflow); end
  endtask

  task automatic test_abort;
    int dn, bc;
    dn = 0; bc = 0;
    fork
      gen(2, 2, 2, 2, 1100);
      begin
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (500) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL abort_busy got %b exp 0", busy); end
        vec++; if (edge_count !== 8'd0) begin err++; $display("FAIL abort_edge_count got %0d exp 0", edge_count); end
        vec++; if (period_min !== 8'd0) begin err++; $display("FAIL abort_period_min got %0d exp 0", period_min); end
        vec++; if (period_max !== 8'd0) begin err++; $display("FAIL abort_period_max got %0d exp 0", period_max); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL abort_overflow got %b exp 0", overflow); end
        vec++; if (no_period !== 1'b0) begin err++; $display("FAIL abort_no_period got %b exp 0", no_period); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) begin
          @(posedge clk); #1;
          if (done) dn++;
          if (busy) bc++;
        end
      end
    join
    vec++; if (dn !== 0) begin err++; $display("FAIL abort_no_done got %0d exp 0", dn); end
    vec++; if (bc !== 0) begin err++; $display("FAIL abort_stays_idle got %0d exp 0", bc); end
  endtask

  task automatic test_ignored_start;
    int lat, bc, dn;
    fork
      gen(2, 2, 2, 2, 1100);
      run_window(300, lat, bc, dn);
    join
    vec++; if (lat !== 1001) begin err++; $display("FAIL ign_latency got %0d exp 1001", lat); end
    vec++; if (bc !== 1000) begin err++; $display("FAIL ign_busy_cycles got %0d exp 1000", bc); end
    vec++; if (dn !== 1) begin err++; $display("FAIL ign_done_pulse got %0d exp 1", dn); end
    vec++; if (edge_count < 8'd249 || edge_count > 8'd251) begin err++; $display("FAIL ign_edge_count got %0d exp 249..251", edge_count); end
  endtask

  initial begin
    test_reset;
    test_periodic("periodic");
    test_mixed;
    test_constant;
    test_single_edge;
    test_sat_edges;
    test_sat_period;
    test_abort;
    test_periodic("post_abort");
    test_ignored_start;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
